// File: rtl/dts_agg.sv
// Die-temperature-sensor alarm aggregator.
// Each raw flag is double-synchronised and debounced; the enabled debounced levels are ORed
// into one registered alarm with a guaranteed minimum high time.
// Optional macro DTS_STICKY_EN builds the sticky trip history and first-fault capture;
// without it those outputs are tied to 0 and clr_i is ignored.
module dts_agg #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned DEB_CNT  = 16,
  parameter int unsigned HOLD_CYC = 64,
  localparam int unsigned IdxW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NUM_CH-1:0] dtsi_i,
  input  logic [NUM_CH-1:0] ch_en_i,
  input  logic              clr_i,
  output logic              dtso_o,
  output logic [NUM_CH-1:0] dts_stat_o,
  output logic [NUM_CH-1:0] dts_sticky_o,
  output logic [IdxW-1:0]   dts_first_o,
  output logic              dts_fvalid_o
);

  typedef enum logic [1:0] {StLow, StQualHi, StHigh, StQualLo} deb_st_e;

  logic [NUM_CH-1:0] sync1_q, sync2_q;
  deb_st_e           st_q   [NUM_CH];
  deb_st_e           st_d   [NUM_CH];
  logic [7:0]        cnt_q  [NUM_CH];
  logic [7:0]        cnt_d  [NUM_CH];
  logic [NUM_CH-1:0] stat_q, stat_d;
  logic              dtso_q, dtso_d;
  logic [15:0]       hold_q, hold_d;
  logic              any_trip;

  // Two-FF synchroniser per channel; inputs are not combined before this point.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= dtsi_i;
      sync2_q <= sync1_q;
    end
  end

  // Debounce next state: a new level must persist DEB_CNT synced cycles to be accepted.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      st_d[i]  = st_q[i];
      cnt_d[i] = cnt_q[i];
      if (!ch_en_i[i]) begin
        st_d[i]  = StLow;
        cnt_d[i] = 8'd0;
      end else begin
        case (st_q[i])
          StLow: begin
            if (sync2_q[i]) begin
              st_d[i]  = StQualHi;
              cnt_d[i] = 8'd1;
            end
          end
          StQualHi: begin
            if (!sync2_q[i]) begin
              st_d[i]  = StLow;
              cnt_d[i] = 8'd0;
            end else if (cnt_q[i] + 8'd1 == 8'(DEB_CNT)) begin
              st_d[i]  = StHigh;
              cnt_d[i] = 8'd0;
            end else begin
              cnt_d[i] = cnt_q[i] + 8'd1;
            end
          end
          StHigh: begin
            if (!sync2_q[i]) begin
              st_d[i]  = StQualLo;
              cnt_d[i] = 8'd1;
            end
          end
          StQualLo: begin
            if (sync2_q[i]) begin
              st_d[i]  = StHigh;
              cnt_d[i] = 8'd0;
            end else if (cnt_q[i] + 8'd1 == 8'(DEB_CNT)) begin
              st_d[i]  = StLow;
              cnt_d[i] = 8'd0;
            end else begin
              cnt_d[i] = cnt_q[i] + 8'd1;
            end
          end
          default: begin
            st_d[i]  = StLow;
            cnt_d[i] = 8'd0;
          end
        endcase
      end
      stat_d[i] = (st_d[i] == StHigh) || (st_d[i] == StQualLo);
    end
  end

  // Debounce state, counters and the registered per-channel level.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_CH; i++) begin
        st_q[i]  <= StLow;
        cnt_q[i] <= 8'd0;
      end
      stat_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        st_q[i]  <= st_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      stat_q <= stat_d;
    end
  end

  assign any_trip = |(stat_q & ch_en_i);

  // Alarm: the hold counter loads only on the rising edge, so re-trips never extend it.
  always_comb begin
    dtso_d = dtso_q;
    hold_d = (hold_q != 16'd0) ? hold_q - 16'd1 : 16'd0;
    if (!dtso_q) begin
      if (any_trip) begin
        dtso_d = 1'b1;
        hold_d = 16'(HOLD_CYC - 1);
      end
    end else if (!any_trip && (hold_q == 16'd0)) begin
      dtso_d = 1'b0;
    end
  end

  // Alarm output and hold counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dtso_q <= 1'b0;
      hold_q <= 16'd0;
    end else begin
      dtso_q <= dtso_d;
      hold_q <= hold_d;
    end
  end

  assign dtso_o     = dtso_q;
  assign dts_stat_o = stat_q;

`ifdef DTS_STICKY_EN
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] sticky_q, sticky_d;
  logic [IdxW-1:0]   first_q, first_d, low_idx;
  logic              fvalid_q, fvalid_d;

  // Sticky/first-fault update; a trip on the same edge as clr_i survives the clear.
  always_comb begin
    rise     = stat_d & ~stat_q;
    low_idx  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (rise[i]) low_idx = IdxW'(i);
    end
    sticky_d = (clr_i ? '0 : sticky_q) | rise;
    first_d  = clr_i ? '0 : first_q;
    fvalid_d = clr_i ? 1'b0 : fvalid_q;
    if (!fvalid_d && (|rise)) begin
      first_d  = low_idx;
      fvalid_d = 1'b1;
    end
  end

  // Trip history registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sticky_q <= '0;
      first_q  <= '0;
      fvalid_q <= 1'b0;
    end else begin
      sticky_q <= sticky_d;
      first_q  <= first_d;
      fvalid_q <= fvalid_d;
    end
  end

  assign dts_sticky_o = sticky_q;
  assign dts_first_o  = first_q;
  assign dts_fvalid_o = fvalid_q;
`else
  logic unused_clr;
  assign unused_clr   = clr_i;
  assign dts_sticky_o = '0;
  assign dts_first_o  = '0;
  assign dts_fvalid_o = 1'b0;
`endif

endmodule

// File: tb/tb_dts_agg.sv
// Directed bench for dts_agg with NUM_CH=4, DEB_CNT=4, HOLD_CYC=8.
// Sticky/first-fault expectations follow whether DTS_STICKY_EN is defined for the build.
module tb_dts_agg;

`ifdef DTS_STICKY_EN
  localparam bit StickyOn = 1'b1;
`else
  localparam bit StickyOn = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [3:0] dtsi;
  logic [3:0] ch_en;
  logic       clr;
  logic       dtso;
  logic [3:0] stat;
  logic [3:0] sticky;
  logic [1:0] first;
  logic       fvalid;

  int n_cmp = 0;
  int n_err = 0;

  dts_agg #(
    .NUM_CH  (4),
    .DEB_CNT (4),
    .HOLD_CYC(8)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .dtsi_i      (dtsi),
    .ch_en_i     (ch_en),
    .clr_i       (clr),
    .dtso_o      (dtso),
    .dts_stat_o  (stat),
    .dts_sticky_o(sticky),
    .dts_first_o (first),
    .dts_fvalid_o(fvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    dtsi  = 4'h0;
    clr   = 1'b0;
    ch_en = 4'hF;
    step(2);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    dtsi  = 4'h0;
    ch_en = 4'hF;
    clr   = 1'b0;

    // 1. Reset mid-trip, then qualification from scratch.
    do_reset();
    dtsi = 4'hF;
    step(6);
    chk("t1_stat_e6", 32'(stat), 32'hF);
    chk("t1_dtso_e6", 32'(dtso), 32'h0);
    step(1);
    chk("t1_dtso_e7", 32'(dtso), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("t1_rst_all", 32'({dtso, stat, sticky, first, fvalid}), 32'h0);
    step(2);
    rst_n = 1'b1;
    step(1);
    chk("t1_rel_all", 32'({dtso, stat, sticky, first, fvalid}), 32'h0);
    for (int e = 2; e <= 5; e++) begin
      step(1);
      chk($sformatf("t1_stat_low_e%0d", e), 32'(stat), 32'h0);
    end
    step(1);
    chk("t1_stat_hi_e6", 32'(stat), 32'hF);

    // 2. Short glitch is filtered; a held level qualifies.
    do_reset();
    dtsi = 4'b0010;
    step(3);
    dtsi = 4'h0;
    for (int e = 4; e <= 12; e++) begin
      step(1);
      chk($sformatf("t2_glitch_e%0d", e), 32'({dtso, stat, sticky}), 32'h0);
    end
    dtsi = 4'b0010;
    step(5);
    chk("t2_stat_e5", 32'(stat), 32'h0);
    step(1);
    chk("t2_stat_e6", 32'(stat), 32'h2);
    chk("t2_dtso_e6", 32'(dtso), 32'h0);
    chk("t2_sticky_e6", 32'(sticky), StickyOn ? 32'h2 : 32'h0);
    chk("t2_first_e6", 32'({first, fvalid}), StickyOn ? 32'h3 : 32'h0);
    step(1);
    chk("t2_dtso_e7", 32'(dtso), 32'h1);

    // 3. Minimum hold for a brief trip, then a long trip.
    do_reset();
    dtsi = 4'b0100;
    step(6);
    chk("t3_stat_q", 32'(stat), 32'h4);
    dtsi = 4'h0;
    for (int e = 1; e <= 8; e++) begin
      step(1);
      chk($sformatf("t3_hold_e%0d", e), 32'(dtso), 32'h1);
      if (e == 5) chk("t3_stat_e5", 32'(stat), 32'h4);
      if (e == 6) chk("t3_stat_e6", 32'(stat), 32'h0);
    end
    step(1);
    chk("t3_dtso_fall", 32'(dtso), 32'h0);
    dtsi = 4'b0100;
    step(7);
    chk("t3_long_rise", 32'(dtso), 32'h1);
    step(20);
    chk("t3_long_held", 32'(dtso), 32'h1);
    dtsi = 4'h0;
    step(6);
    chk("t3_long_stat", 32'(stat), 32'h0);
    chk("t3_long_d6", 32'(dtso), 32'h1);
    step(1);
    chk("t3_long_d7", 32'(dtso), 32'h0);

    // 4. Simultaneous trip, CLR, and CLR coinciding with a trip.
    do_reset();
    dtsi = 4'b1001;
    step(6);
    chk("t4_stat", 32'(stat), 32'h9);
    chk("t4_sticky", 32'(sticky), StickyOn ? 32'h9 : 32'h0);
    chk("t4_first", 32'(first), 32'h0);
    chk("t4_fvalid", 32'(fvalid), StickyOn ? 32'h1 : 32'h0);
    dtsi = 4'b0001;
    clr  = 1'b1;
    step(1);
    clr = 1'b0;
    chk("t4_clr_sticky", 32'(sticky), 32'h0);
    chk("t4_clr_fvalid", 32'(fvalid), 32'h0);
    chk("t4_clr_stat", 32'(stat), 32'h9);
    chk("t4_clr_dtso", 32'(dtso), 32'h1);
    step(5);
    chk("t4_ch3_low", 32'(stat), 32'h1);
    dtsi = 4'b1001;
    step(5);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    chk("t4_race_stat", 32'(stat), 32'h9);
    chk("t4_race_sticky", 32'(sticky), StickyOn ? 32'h8 : 32'h0);
    chk("t4_race_first", 32'({first, fvalid}), StickyOn ? 32'h7 : 32'h0);

    // 5. Disable a tripped channel, hold expiry, re-enable.
    do_reset();
    dtsi = 4'b0001;
    step(7);
    chk("t5_dtso_on", 32'(dtso), 32'h1);
    ch_en = 4'b1110;
    step(1);
    chk("t5_stat_off", 32'(stat), 32'h0);
    step(6);
    chk("t5_hold_h8", 32'(dtso), 32'h1);
    step(1);
    chk("t5_fall_h9", 32'(dtso), 32'h0);
    ch_en = 4'hF;
    step(3);
    chk("t5_reen_e3", 32'(stat), 32'h0);
    step(1);
    chk("t5_reen_e4", 32'(stat), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
